seg7_scan_mux: RTL and testbench
================================

# seg7_scan_mux

Parametrised N-digit multiplexed seven-segment driver. It is the successor to the fixed 4-digit display controller and sits between the PS/2 data path (or any producer with a valid/data strobe) and the board's anode/cathode pins. Compared with the fixed controller it adds:
- configurable digit count and refresh rate;
- per-digit decimal points;
- optional leading-zero blanking;
- tear-free updates: new data is held in a shadow register and applied only at a frame boundary.

## Interface
- `DIGITS`, default 4: number of digits scanned; legal range 1..8.
- `REFRESH_DIV`, default 100000: clk_sys cycles per digit slot; legal range ≥1. The default gives 1 kHz per digit at 100 MHz.
- `ACTIVE_LOW`, default 1: when 1, both select and segment outputs are active-low; when 0, both are active-high.

Ports (one clock; reset is asynchronous and active-high):
- `clk_sys`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `upd_vld`  in  1  single-cycle strobe; capture `upd_data` and `upd_dp`.
- `upd_data`  in  4*DIGITS  hex nibbles; nibble k drives digit k (digit 0 is rightmost).
- `upd_dp`  in  DIGITS  decimal-point enable per digit.
- `lz_blank`  in  1  level input; enables leading-zero blanking.
- `seg_select_out`  out  DIGITS  one-hot digit enable (polarity set by `ACTIVE_LOW`).
- `hex_out`  out  8  bit 7 = dp; bits 6..0 = segments g..a (polarity set by `ACTIVE_LOW`).
- `frame_done`  out  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0.

## Operation
Prescaler:
- `div_cnt` counts 0..REFRESH_DIV-1 and wraps to 0.
- `tick` is asserted when `div_cnt` = REFRESH_DIV-1.
- With REFRESH_DIV = 1, `tick` is asserted every cycle.

Digit index:
- `idx` (width clog2(DIGITS), minimum 1 bit) advances on `tick`.
- When `idx` = DIGITS-1 and `tick` is asserted: `idx` wraps to 0 and the cycle is a wrap event.

Shadow/display registers:
- On `upd_vld`, `{upd_data, upd_dp}` is written to the shadow register and `pend` is set to 1.
- On a wrap event with `pend` = 1: the display register loads from the shadow and `pend` clears.
- `upd_vld` coinciding with a wrap event: the incoming data goes straight to the display register and `pend` is left at 0.
- Multiple `upd_vld` strobes within one frame: the last one wins.

Blanking:
- With `lz_blank` = 1, digit k is blanked if every nibble at position ≥ k is 0 and k ≠ 0. Digit 0 is never blanked.
- A blanked digit drives all segments off, but its dp bit still follows `upd_dp`.
- `lz_blank` is sampled combinationally against the display register; it is not shadowed.

Decode (active-high form, bits g..a):
- 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F
- A=77, b=7C, C=39, d=5E, E=79, F=71
- When `ACTIVE_LOW` = 1, all 8 bits of `hex_out` and all bits of `seg_select_out` are inverted.

Outputs: `seg_select_out`, `hex_out` and `frame_done` are all registered.

## Timing
- Reset values:
  - `div_cnt` = 0, `idx` = 0, `pend` = 0, shadow = 0, display = 0.
  - `frame_done` = 0.
  - `seg_select_out` and `hex_out` = all segments and digits off (all 1s when `ACTIVE_LOW` = 1).
- First cycle after reset release: outputs show digit 0 = "0" with no dp.
- Output latency: outputs reflect `idx` and the display register one cycle after either changes.
- Each digit is driven for exactly REFRESH_DIV cycles; a frame is DIGITS*REFRESH_DIV cycles.
- `frame_done` rises in the cycle after the wrap event and lasts one cycle.
- Update latency: if `upd_vld` is sampled at cycle t, the new value first appears on `hex_out` one cycle after the next wrap event at or after t. Worst case is DIGITS*REFRESH_DIV+1 cycles.
- Reset asserted mid-frame: all registers return immediately (asynchronously) to reset values. Pending data is discarded.
- `DIGITS` = 1: a wrap event occurs on every `tick`, and `seg_select_out` is constant-on after the first cycle.

## Test plan
- **Reset/idle:** DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1, release reset. Expected: `seg_select_out` cycles 1110→1101→1011→0111, 4 cycles each; digit 0 `hex_out` = 8'hC0; other digits also 8'hC0 when `lz_blank`=0.
- **Tear-free update:** pulse `upd_vld` with `upd_data`=16'h12AF during digit 1. Expected: digits 2 and 3 still show 0 for the rest of that frame; after `frame_done`, digits 0..3 show F(8E), A(88), 2(A4), 1(F9).
- **Coincident update and wrap:** assert `upd_vld` with 16'h0005 exactly on a wrap event. Expected: digit 0 shows 8'h92 in the very next cycle, and `pend` remains 0.
- **Leading-zero blanking:** `lz_blank`=1, data 16'h0030, `upd_dp`=4'b1000. Expected: digit 3 = 8'h7F (blank segments, dp on), digit 2 = 8'hFF, digit 1 = 8'hB0, digit 0 = 8'hC0.
- **Last-write-wins and reset mid-frame:** two strobes in one frame (16'h1111 then 16'h2222). Expected: display shows 2222. Then assert `rst` mid-digit: outputs go all-1s immediately, and after release the display shows 0000 with no stale pending data applied.
- **Parameter corners:** DIGITS=1 with REFRESH_DIV=1, and DIGITS=8 with ACTIVE_LOW=0. Expected: `frame_done` every cycle in the first case; in the second, one-hot high select, and 8'h06 for nibble 1.

Source files
------------

// File: rtl/seg7_scan_mux.sv
// N-digit multiplexed seven-segment driver with tear-free shadowed updates,
// per-digit decimal points and optional leading-zero blanking.
module seg7_scan_mux #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned ACTIVE_LOW  = 1
) (
    input  logic                  clk_sys,
    input  logic                  rst,
    input  logic                  upd_vld,
    input  logic [4*DIGITS-1:0]   upd_data,
    input  logic [DIGITS-1:0]     upd_dp,
    input  logic                  lz_blank,
    output logic [DIGITS-1:0]     seg_select_out,
    output logic [7:0]            hex_out,
    output logic                  frame_done
);

    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned DIV_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned DATA_W = 4 * DIGITS;

    localparam logic [7:0]        HEX_OFF = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] SEL_OFF = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : '0;

    logic [DIV_W-1:0]  r_div_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_shad_data;
    logic [DIGITS-1:0] r_shad_dp;
    logic [DATA_W-1:0] r_disp_data;
    logic [DIGITS-1:0] r_disp_dp;
    logic              r_pend;
    logic [DIGITS-1:0] r_sel;
    logic [7:0]        r_hex;
    logic              r_frame_done;

    logic              w_tick;
    logic              w_last;
    logic              w_wrap;
    logic [3:0]        w_nib;
    logic              w_dp;
    logic              w_blank;
    logic [6:0]        w_seg;
    logic [7:0]        w_hex;
    logic [DIGITS-1:0] w_sel;

    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    assign w_tick = (r_div_cnt == DIV_W'(REFRESH_DIV - 1));
    assign w_last = (r_idx == IDX_W'(DIGITS - 1));
    assign w_wrap = w_tick & w_last;

    // Prescaler and digit index
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_idx     <= '0;
        end else begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
            if (w_tick) begin
                r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
            end
        end
    end

    // Shadow holds new data until the frame boundary so a frame never mixes old and new digits
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            r_shad_data <= '0;
            r_shad_dp   <= '0;
            r_disp_data <= '0;
            r_disp_dp   <= '0;
            r_pend      <= 1'b0;
        end else if (upd_vld) begin
            r_shad_data <= upd_data;
            r_shad_dp   <= upd_dp;
            if (w_wrap) begin
                r_disp_data <= upd_data;
                r_disp_dp   <= upd_dp;
                r_pend      <= 1'b0;
            end else begin
                r_pend      <= 1'b1;
            end
        end else if (w_wrap && r_pend) begin
            r_disp_data <= r_shad_data;
            r_disp_dp   <= r_shad_dp;
            r_pend      <= 1'b0;
        end
    end

    // Select current nibble; a digit is blank when it and every digit to its left are zero
    always_comb begin
        logic hi_zero;
        w_nib   = '0;
        w_dp    = 1'b0;
        w_blank = 1'b0;
        hi_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            hi_zero = hi_zero & (r_disp_data[4*k +: 4] == 4'h0);
            if (r_idx == IDX_W'(k)) begin
                w_nib   = r_disp_data[4*k +: 4];
                w_dp    = r_disp_dp[k];
                w_blank = lz_blank && (k != 0) && hi_zero;
            end
        end
    end

    assign w_seg = w_blank ? 7'h00 : f_decode(w_nib);
    assign w_hex = {w_dp, w_seg};
    assign w_sel = DIGITS'(1) << r_idx;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            r_sel        <= SEL_OFF;
            r_hex        <= HEX_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_sel        <= (ACTIVE_LOW != 0) ? ~w_sel : w_sel;
            r_hex        <= (ACTIVE_LOW != 0) ? ~w_hex : w_hex;
            r_frame_done <= w_wrap;
        end
    end

    assign seg_select_out = r_sel;
    assign hex_out        = r_hex;
    assign frame_done     = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux: three parameter sets share one stimulus
// stream; a per-instance frame model predicts every output cycle.
module tb_seg7_scan_mux;

    typedef struct packed {
        logic [7:0] hex;
        logic [7:0] sel;
        logic       fd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        upd_vld;
    logic        lz_blank;
    logic [31:0] upd_data;
    logic [7:0]  upd_dp;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int unsigned D  = (g == 0) ? 4 : (g == 1) ? 1 : 8;
        localparam int unsigned R  = (g == 0) ? 4 : (g == 1) ? 1 : 3;
        localparam int unsigned AL = (g == 2) ? 0 : 1;
        localparam logic [31:0] MASK  = 32'((64'd1 << (4 * D)) - 64'd1);
        localparam logic [7:0]  DMASK = 8'((16'd1 << D) - 16'd1);

        logic [D-1:0] w_sel;
        logic [7:0]   w_hex;
        logic         w_fd;

        seg7_scan_mux #(.DIGITS(D), .REFRESH_DIV(R), .ACTIVE_LOW(AL)) u_dut (
            .clk_sys        (clk),
            .rst            (rst),
            .upd_vld        (upd_vld),
            .upd_data       (upd_data[4*D-1:0]),
            .upd_dp         (upd_dp[D-1:0]),
            .lz_blank       (lz_blank),
            .seg_select_out (w_sel),
            .hex_out        (w_hex),
            .frame_done     (w_fd)
        );

        exp_t        q[$];
        int          e;
        logic [31:0] m_disp, m_shad;
        logic [7:0]  m_dpd, m_dps;
        logic        m_pend;

        // Model: cycle c after reset shows digit (c/R)%D; wrap ends every D*R-cycle frame
        initial begin
            exp_t       x;
            int         c, dig;
            logic       wrap, blank;
            logic [3:0] nib;
            forever begin
                @(posedge clk);
                if (rst) begin
                    e = 0; m_disp = '0; m_shad = '0; m_dpd = '0; m_dps = '0; m_pend = 1'b0;
                    x.hex = (AL != 0) ? 8'hFF : 8'h00;
                    x.sel = (AL != 0) ? DMASK : 8'h00;
                    x.fd  = 1'b0;
                end else begin
                    e++;
                    c     = e - 1;
                    dig   = (c / R) % D;
                    wrap  = ((c % (D * R)) == (D * R - 1));
                    nib   = 4'(m_disp >> (4 * dig));
                    blank = lz_blank && (dig != 0) && ((m_disp >> (4 * dig)) == 32'h0);
                    x.hex = {m_dpd[dig], blank ? 7'h00 : seg_tab[nib]};
                    x.sel = 8'(1 << dig);
                    if (AL != 0) begin
                        x.hex = ~x.hex;
                        x.sel = ~x.sel & DMASK;
                    end
                    x.fd = wrap;
                    if (upd_vld) begin
                        if (wrap) begin
                            m_disp = upd_data & MASK; m_dpd = upd_dp & DMASK; m_pend = 1'b0;
                        end else begin
                            m_shad = upd_data & MASK; m_dps = upd_dp & DMASK; m_pend = 1'b1;
                        end
                    end else if (wrap && m_pend) begin
                        m_disp = m_shad; m_dpd = m_dps; m_pend = 1'b0;
                    end
                end
                q.push_back(x);
            end
        end

        // Monitor: one expected entry per clock, compared mid-cycle
        initial begin
            exp_t x;
            forever begin
                @(negedge clk);
                if (q.size() > 0) begin
                    x = q.pop_front();
                    checks++;
                    if (w_hex !== x.hex || 8'(w_sel) !== x.sel || w_fd !== x.fd) begin
                        errors++;
                        $display("FAIL scoreboard inst%0d t=%0t got hex=%h sel=%h fd=%b expected hex=%h sel=%h fd=%b",
                                 g, $time, w_hex, 8'(w_sel), w_fd, x.hex, x.sel, x.fd);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [31:0] d, input logic [7:0] dp);
        upd_vld  = 1'b1;
        upd_data = d;
        upd_dp   = dp;
        wait_cyc(1);
        upd_vld  = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_hex;
        rst = 1'b1; upd_vld = 1'b0; lz_blank = 1'b0; upd_data = '0; upd_dp = '0;
        wait_cyc(3);
        chk("rst_hex", 32'(g_inst[0].w_hex), 32'hFF);
        chk("rst_sel", 32'(g_inst[0].w_sel), 32'hF);
        chk("rst_hex_ah", 32'(g_inst[2].w_hex), 32'h00);
        rst = 1'b0;
        wait_cyc(1);
        chk("first_hex", 32'(g_inst[0].w_hex), 32'hC0);
        chk("first_sel", 32'(g_inst[0].w_sel), 32'hE);

        // Update mid-frame during digit 1, then one landing exactly on a wrap edge
        wait_cyc(19);
        strobe(32'h12AF, 8'h00);
        wait_cyc(26);
        strobe(32'h0005, 8'h00);
        wait_cyc(1);
        chk("coincident_hex", 32'(g_inst[0].w_hex), 32'h92);
        wait_cyc(20);

        // Leading-zero blanking with dp on the blanked top digit
        lz_blank = 1'b1;
        strobe(32'h0030, 8'h08);
        wait_cyc(40);
        for (int i = 0; i < 16; i++) begin
            case (g_inst[0].w_sel)
                4'hE:    exp_hex = 32'hC0;
                4'hD:    exp_hex = 32'hB0;
                4'hB:    exp_hex = 32'hFF;
                4'h7:    exp_hex = 32'h7F;
                default: exp_hex = 32'hDEAD;
            endcase
            chk("lz_digit", 32'(g_inst[0].w_hex), exp_hex);
            wait_cyc(1);
        end
        lz_blank = 1'b0;

        // Last write wins within a frame
        strobe(32'h1111, 8'h00);
        wait_cyc(2);
        strobe(32'h2222, 8'h00);
        wait_cyc(30);

        // Reset mid-frame with data still pending
        strobe(32'h3333, 8'h0F);
        wait_cyc(2);
        rst = 1'b1;
        #1;
        chk("rst_async_hex", 32'(g_inst[0].w_hex), 32'hFF);
        chk("rst_async_sel", 32'(g_inst[0].w_sel), 32'hF);
        chk("rst_async_ah", 32'(g_inst[2].w_sel), 32'h00);
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(40);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            upd_vld  = ($urandom % 8) == 0;
            upd_data = $urandom;
            upd_dp   = 8'($urandom);
            if (($urandom % 64) == 0) lz_blank = ~lz_blank;
            wait_cyc(1);
        end
        upd_vld = 1'b0;
        wait_cyc(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
